// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the MMIO timer bank.
//   - register offsets within a channel's 8-word window
//   - CTRL / STAT bit positions
//   - ctrl_t: CTRL register image, laid out exactly as it reads on the bus
//   - stat_t: sticky flag set, laid out as the low bits of STAT
//   - ctrl_from_word: turns a bus write into a legal CTRL image
// The capture feature is compiled in only when TIMER_CAPTURE_EN is defined.
package timer_pkg;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_CNT  = 3'd1;
  localparam logic [2:0] REG_CMP  = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_CAP  = 3'd4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AR_BIT     = 1;
  localparam int CTRL_OVF_IE_BIT = 2;
  localparam int CTRL_CMP_IE_BIT = 3;
  localparam int CTRL_CAP_IE_BIT = 4;
  localparam int CTRL_PRESC_LSB  = 8;
  localparam int PRESC_MAX_W     = 24;

  localparam int STAT_OVF_BIT   = 0;
  localparam int STAT_MATCH_BIT = 1;
  localparam int STAT_CAP_BIT   = 2;

  typedef struct packed {
    logic [PRESC_MAX_W-1:0] presc;
    logic [2:0]             rsvd;
    logic                   cap_ie;
    logic                   cmp_ie;
    logic                   ovf_ie;
    logic                   auto_reload;
    logic                   en;
  } ctrl_t;

  typedef struct packed {
    logic cap;
    logic match;
    logic ovf;
  } stat_t;

  // Reserved bits, prescaler bits beyond the configured width and, when
  // capture is not built, CAP_IE are forced to zero so they read back as 0.
  function automatic ctrl_t ctrl_from_word(logic [31:0] word, int presc_w, bit cap_en);
    ctrl_t c;
    c      = ctrl_t'(word);
    c.rsvd = '0;
    for (int b = 0; b < PRESC_MAX_W; b++) begin
      if (b >= presc_w) c.presc[b] = 1'b0;
    end
    if (!cap_en) c.cap_ie = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer/counter channel of mmio_timer_bank.
// Holds CTRL, CNT, CMP, STAT and CAP plus the prescaler for one channel.
// Ports:
//   clk, Rst_n            clock, asynchronous active-low reset
//   wr_ctrl/cnt/cmp/stat  decoded one-cycle write strobes for this channel
//   wdata                 bus write data
//   cnt_zero              synchronous counter clear
//   cap_in                capture strobe (used only with TIMER_CAPTURE_EN)
//   ctrl, cnt, cmp, cap   register contents for the read mux
//   stat                  sticky flags
//   irq_req               this channel's enabled-flag request (unregistered)
// TIMER_CAPTURE_EN: when defined, a rising cap_in latches CNT into CAP and
// sets STAT.CAP; otherwise CAP and STAT.CAP are constant zero.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             wr_ctrl,
  input  logic             wr_cnt,
  input  logic             wr_cmp,
  input  logic             wr_stat,
  input  logic [31:0]      wdata,
  input  logic             cnt_zero,
  input  logic             cap_in,
  output ctrl_t            ctrl,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] cap,
  output stat_t            stat,
  output logic             irq_req
);

`ifdef TIMER_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0]   CNT_ONES = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic               ovf_set;
  logic               match_set;
  logic               ovf_q;
  logic               match_q;
  logic               cap_q;

  assign tick      = ctrl.en && (pcnt == ctrl.presc[PRESC_W-1:0]);
  assign ovf_set   = tick && (cnt == CNT_ONES);
  assign match_set = tick && (cnt == cmp);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl <= '0;
      cmp  <= '0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_from_word(wdata, PRESC_W, CAP_EN);
      if (wr_cmp)  cmp  <= wdata[CNT_W-1:0];
    end
  end

  // Prescaler restarts on any CTRL write or hardware clear so a new
  // configuration always begins a full (PRESC+1)-cycle interval.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pcnt <= '0;
    end else if (cnt_zero || wr_ctrl || !ctrl.en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_ONE;
    end
  end

  // Auto-reload returns to 0 on the matching tick; plain counting wraps.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (cnt_zero) begin
      cnt <= '0;
    end else if (wr_cnt) begin
      cnt <= wdata[CNT_W-1:0];
    end else if (tick) begin
      if (ctrl.auto_reload && match_set) cnt <= '0;
      else                               cnt <= cnt + CNT_ONE;
    end
  end

  // W1C: a hardware set in the same cycle overrides the clear.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      ovf_q   <= (ovf_q   && !(wr_stat && wdata[STAT_OVF_BIT]))   || ovf_set;
      match_q <= (match_q && !(wr_stat && wdata[STAT_MATCH_BIT])) || match_set;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic cap_in_d;
  logic cap_edge;

  assign cap_edge = cap_in && !cap_in_d;

  // cap is sampled before this cycle's tick, so a coincident edge captures
  // the pre-increment count.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cap_in_d <= 1'b0;
      cap      <= '0;
      cap_q    <= 1'b0;
    end else begin
      cap_in_d <= cap_in;
      if (cap_edge) cap <= cnt;
      cap_q <= (cap_q && !(wr_stat && wdata[STAT_CAP_BIT])) || cap_edge;
    end
  end
`else
  logic unused_cap_in;
  assign unused_cap_in = cap_in;
  assign cap           = '0;
  assign cap_q         = 1'b0;
`endif

  assign stat    = {cap_q, match_q, ovf_q};
  assign irq_req = (ovf_q & ctrl.ovf_ie) | (match_q & ctrl.cmp_ie) | (cap_q & ctrl.cap_ie);

endmodule

// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank: multi-channel MMIO timer/counter bank.
// Each channel has a prescaler, CNT_W-bit up-counter, compare with optional
// auto-reload and sticky OVF/MATCH(/CAP) flags; one level interrupt line.
// Ports:
//   clk, Rst_n   clock, asynchronous active-low reset
//   wr_en, rd_en one-cycle bus strobes
//   addr         word address: [2:0] register, upper bits channel
//   wdata        write data
//   rdata        registered read data, valid while rd_valid is high
//   rd_valid     high the cycle after rd_en
//   cnt_zero     per-channel synchronous counter clear
//   cap_in       per-channel capture strobes
//   irq          registered OR of all enabled channel flags
// TIMER_CAPTURE_EN: define to build the capture register and STAT.CAP.
module mmio_timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic                       clk,
  input  logic                       Rst_n,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [$clog2(NUM_CH)+2:0]  addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       rd_valid,
  input  logic [NUM_CH-1:0]          cnt_zero,
  input  logic [NUM_CH-1:0]          cap_in,
  output logic                       irq
);

  logic [2:0]       reg_sel;
  logic [31:0]      ch_idx;
  logic [31:0]      rd_word;
  logic [NUM_CH-1:0] ch_irq;

  ctrl_t            ch_ctrl [NUM_CH];
  stat_t            ch_stat [NUM_CH];
  logic [CNT_W-1:0] ch_cnt  [NUM_CH];
  logic [CNT_W-1:0] ch_cmp  [NUM_CH];
  logic [CNT_W-1:0] ch_cap  [NUM_CH];

  // Channel numbers at or above NUM_CH match no generate instance, so such
  // writes are dropped and reads fall through to zero.
  assign reg_sel = addr[2:0];
  assign ch_idx  = 32'(addr) >> 3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (ch_idx == 32'(i));

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_channel (
      .clk      (clk),
      .Rst_n    (Rst_n),
      .wr_ctrl  (ch_wr && (reg_sel == REG_CTRL)),
      .wr_cnt   (ch_wr && (reg_sel == REG_CNT)),
      .wr_cmp   (ch_wr && (reg_sel == REG_CMP)),
      .wr_stat  (ch_wr && (reg_sel == REG_STAT)),
      .wdata    (wdata),
      .cnt_zero (cnt_zero[i]),
      .cap_in   (cap_in[i]),
      .ctrl     (ch_ctrl[i]),
      .cnt      (ch_cnt[i]),
      .cmp      (ch_cmp[i]),
      .cap      (ch_cap[i]),
      .stat     (ch_stat[i]),
      .irq_req  (ch_irq[i])
    );
  end

  // Read mux sees pre-write register state, giving read-before-write
  // ordering when a read and write hit the same register together.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) begin
        case (reg_sel)
          REG_CTRL: rd_word = ch_ctrl[i];
          REG_CNT:  rd_word = 32'(ch_cnt[i]);
          REG_CMP:  rd_word = 32'(ch_cmp[i]);
          REG_STAT: rd_word = {29'd0, ch_stat[i]};
          REG_CAP:  rd_word = 32'(ch_cap[i]);
          default:  rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (rd_en) rdata <= rd_word;
      rd_valid <= rd_en;
      irq      <= |ch_irq;
    end
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// tb_mmio_timer_bank: self-checking bench for mmio_timer_bank (4 channels,
// 8-bit counters). A cycle-level model built from the register rules
// predicts rdata, rd_valid and irq. Honours TIMER_CAPTURE_EN.
module tb_mmio_timer_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
  localparam int unsigned CNT_MASK = CNT_MAX;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        wr_en, rd_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_valid;
  logic [3:0]  cnt_zero, cap_in;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  mmio_timer_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .cnt_zero (cnt_zero),
    .cap_in   (cap_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_cnt[NUM_CH], m_cmp[NUM_CH], m_pc[NUM_CH], m_presc[NUM_CH], m_cap[NUM_CH];
  bit m_en[NUM_CH], m_ar[NUM_CH], m_oie[NUM_CH], m_mie[NUM_CH], m_cie[NUM_CH];
  bit m_ovf[NUM_CH], m_mat[NUM_CH], m_capf[NUM_CH], m_capd[NUM_CH];
  logic [31:0] m_rdata;
  bit m_rdv, m_irq;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_cmp[c] = 0; m_pc[c] = 0; m_presc[c] = 0; m_cap[c] = 0;
      m_en[c] = 0; m_ar[c] = 0; m_oie[c] = 0; m_mie[c] = 0; m_cie[c] = 0;
      m_ovf[c] = 0; m_mat[c] = 0; m_capf[c] = 0; m_capd[c] = 0;
    end
    m_rdata = 32'h0; m_rdv = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] model_read(int ch, int r);
    if (ch >= NUM_CH) return 32'h0;
    case (r)
      0: return (m_presc[ch] << 8) | (32'(m_cie[ch]) << 4) | (32'(m_mie[ch]) << 3) |
                (32'(m_oie[ch]) << 2) | (32'(m_ar[ch]) << 1) | 32'(m_en[ch]);
      1: return m_cnt[ch];
      2: return m_cmp[ch];
      3: return (32'(m_capf[ch]) << 2) | (32'(m_mat[ch]) << 1) | 32'(m_ovf[ch]);
      4: return m_cap[ch];
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit any_irq;
    int sel_ch, r;
    any_irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      any_irq |= (m_ovf[c] && m_oie[c]) || (m_mat[c] && m_mie[c]) || (m_capf[c] && m_cie[c]);
    sel_ch = int'(addr >> 3);
    r      = int'(addr[2:0]);
    if (rd_en) m_rdata = model_read(sel_ch, r);
    m_rdv = rd_en;
    m_irq = any_irq;
    for (int c = 0; c < NUM_CH; c++) begin
      bit wsel, tick;
      int unsigned old_cnt;
      wsel    = wr_en && (sel_ch == c);
      tick    = m_en[c] && (m_pc[c] == m_presc[c]);
      old_cnt = m_cnt[c];
      if (cnt_zero[c] || (wsel && r == 0) || !m_en[c] || tick) m_pc[c] = 0;
      else m_pc[c] = m_pc[c] + 1;
      if (cnt_zero[c]) m_cnt[c] = 0;
      else if (wsel && r == 1) m_cnt[c] = wdata & CNT_MASK;
      else if (tick) m_cnt[c] = (m_ar[c] && old_cnt == m_cmp[c]) ? 0 : (old_cnt + 1) % (CNT_MAX + 1);
      m_ovf[c] = (m_ovf[c] && !(wsel && r == 3 && wdata[0])) || (tick && old_cnt == CNT_MAX);
      m_mat[c] = (m_mat[c] && !(wsel && r == 3 && wdata[1])) || (tick && old_cnt == m_cmp[c]);
`ifdef TIMER_CAPTURE_EN
      begin
        bit edge_seen;
        edge_seen = cap_in[c] && !m_capd[c];
        m_capf[c] = (m_capf[c] && !(wsel && r == 3 && wdata[2])) || edge_seen;
        if (edge_seen) m_cap[c] = old_cnt;
      end
`endif
      m_capd[c] = cap_in[c];
      if (wsel && r == 0) begin
        m_en[c]    = wdata[0];
        m_ar[c]    = wdata[1];
        m_oie[c]   = wdata[2];
        m_mie[c]   = wdata[3];
`ifdef TIMER_CAPTURE_EN
        m_cie[c]   = wdata[4];
`else
        m_cie[c]   = 1'b0;
`endif
        m_presc[c] = (wdata >> 8) & ((1 << PRESC_W) - 1);
      end
      if (wsel && r == 2) m_cmp[c] = wdata & CNT_MASK;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ra(int ch, int r);
    return 5'((ch << 3) | r);
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL reset_irq: got %b expected %b", irq, m_irq);
    end
    vectors++;
    if (rd_valid !== m_rdv) begin
      miscompares++; $display("[TB] FAIL reset_rd_valid: got %b expected %b", rd_valid, m_rdv);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < 8; r++) begin
        bus_read(ra(c, r));
        vectors++;
        if (rd_valid !== 1'b1 || rdata !== m_rdata) begin
          miscompares++;
          $display("[TB] FAIL reset_reg ch%0d r%0d: got %h/%b expected %h/1", c, r, rdata, rd_valid, m_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    bus_write(ra(1, 1), 32'h55);
    bus_write(ra(1, 2), 32'h57);
    bus_write(ra(1, 0), 32'h0000_0009);
    repeat (5) step();
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL midrst_irq_before: got %b expected %b", irq, m_irq);
    end
    bus_read(ra(1, 1));
    vectors++;
    if (rdata !== m_rdata) begin
      miscompares++; $display("[TB] FAIL midrst_cnt_before: got %h expected %h", rdata, m_rdata);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    vectors++;
    if (rdata !== 32'h0 || irq !== 1'b0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got rdata=%h irq=%b rd_valid=%b expected 0/0/0", rdata, irq, rd_valid);
    end
    model_reset();
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    for (int r = 0; r < 5; r++) begin
      bus_read(ra(1, r));
      vectors++;
      if (rdata !== m_rdata) begin
        miscompares++; $display("[TB] FAIL midrst_reg r%0d: got %h expected %h", r, rdata, m_rdata);
      end
    end
  endtask

  task automatic test_auto_reload();
    bus_write(ra(0, 2), 32'd9);
    bus_write(ra(0, 0), 32'h0000_000B);
    rd_en = 1'b1; addr = ra(0, 1);
    for (int k = 0; k < 25; k++) begin
      step();
      vectors++;
      if (rdata !== m_rdata || irq !== m_irq) begin
        miscompares++;
        $display("[TB] FAIL auto_reload cyc%0d: got cnt=%h irq=%b expected cnt=%h irq=%b", k, rdata, irq, m_rdata, m_irq);
      end
    end
    rd_en = 1'b0;
    bus_write(ra(0, 0), 32'h0);
    bus_write(ra(0, 3), 32'h7);
    bus_read(ra(0, 3));
    vectors++;
    if (rdata !== m_rdata) begin
      miscompares++; $display("[TB] FAIL auto_reload_stat: got %h expected %h", rdata, m_rdata);
    end
  endtask

  task automatic test_overflow();
    bus_write(ra(1, 1), 32'hFE);
    bus_write(ra(1, 0), 32'h0000_0301);
    rd_en = 1'b1; addr = ra(1, 3);
    for (int k = 0; k < 12; k++) begin
      step();
      vectors++;
      if (rdata !== m_rdata || irq !== m_irq) begin
        miscompares++;
        $display("[TB] FAIL overflow cyc%0d: got stat=%h irq=%b expected stat=%h irq=%b", k, rdata, irq, m_rdata, m_irq);
      end
    end
    rd_en = 1'b0;
    bus_read(ra(1, 1));
    vectors++;
    if (rdata !== m_rdata) begin
      miscompares++; $display("[TB] FAIL overflow_cnt: got %h expected %h", rdata, m_rdata);
    end
    bus_write(ra(1, 0), 32'h0000_0305);
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (irq !== m_irq) begin
        miscompares++; $display("[TB] FAIL overflow_irq cyc%0d: got %b expected %b", k, irq, m_irq);
      end
    end
    bus_write(ra(1, 0), 32'h0);
    bus_write(ra(1, 3), 32'h7);
  endtask

  task automatic test_w1c_race();
    bus_write(ra(2, 1), 32'hFD);
    bus_write(ra(2, 0), 32'h0000_0005);
    step();
    step();
    bus_write(ra(2, 3), 32'h1);
    bus_write(ra(2, 0), 32'h0000_0004);
    bus_read(ra(2, 3));
    vectors++;
    if (rdata !== m_rdata) begin
      miscompares++; $display("[TB] FAIL w1c_race_stat: got %h expected %h", rdata, m_rdata);
    end
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL w1c_race_irq: got %b expected %b", irq, m_irq);
    end
    bus_write(ra(2, 3), 32'h1);
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL w1c_clear_irq0: got %b expected %b", irq, m_irq);
    end
    step();
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL w1c_clear_irq1: got %b expected %b", irq, m_irq);
    end
  endtask

  task automatic test_cnt_zero();
    for (int c = 0; c < NUM_CH; c++) begin
      bus_write(ra(c, 1), 32'(8'h10 * c + 3));
      bus_write(ra(c, 0), 32'h0000_0001);
    end
    cnt_zero = 4'b0100;
    wr_en = 1'b1; addr = ra(2, 1); wdata = 32'h77;
    step();
    cnt_zero = 4'b0000; wr_en = 1'b0;
    for (int c = 2; c < NUM_CH + 2; c++) begin
      bus_read(ra(c % NUM_CH, 1));
      vectors++;
      if (rdata !== m_rdata) begin
        miscompares++; $display("[TB] FAIL cnt_zero ch%0d: got %h expected %h", c % NUM_CH, rdata, m_rdata);
      end
    end
    for (int c = 0; c < NUM_CH; c++) bus_write(ra(c, 0), 32'h0);
  endtask

  task automatic test_back_to_back();
    bus_write(ra(3, 2), 32'h12);
    wr_en = 1'b1; rd_en = 1'b1; addr = ra(3, 2); wdata = 32'h34;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    vectors++;
    if (rdata !== m_rdata) begin
      miscompares++; $display("[TB] FAIL rw_same_cycle: got %h expected %h", rdata, m_rdata);
    end
    bus_read(ra(3, 2));
    vectors++;
    if (rdata !== m_rdata) begin
      miscompares++; $display("[TB] FAIL rw_after: got %h expected %h", rdata, m_rdata);
    end
  endtask

  task automatic test_capture();
    bus_write(ra(1, 3), 32'h7);
    bus_write(ra(1, 1), 32'h1C);
    bus_write(ra(1, 0), 32'h0000_0011);
    repeat (4) step();
    cap_in[1] = 1'b1;
    step();
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL capture_irq0: got %b expected %b", irq, m_irq);
    end
    step();
    cap_in[1] = 1'b0;
    vectors++;
    if (irq !== m_irq) begin
      miscompares++; $display("[TB] FAIL capture_irq1: got %b expected %b", irq, m_irq);
    end
    for (int r = 0; r < 5; r++) begin
      bus_read(ra(1, r));
      vectors++;
      if (rdata !== m_rdata) begin
        miscompares++; $display("[TB] FAIL capture_reg r%0d: got %h expected %h", r, rdata, m_rdata);
      end
    end
    bus_write(ra(1, 0), 32'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      int r;
      r      = $urandom_range(0, 7);
      wr_en  = ($urandom_range(0, 3) == 0);
      rd_en  = $urandom_range(0, 1) == 1;
      addr   = 5'(($urandom_range(0, 3) << 3) | r);
      if (r == 0)
        wdata = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 8) | ($urandom & 32'hFF) | 32'h1;
      else
        wdata = $urandom;
      cnt_zero = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      cap_in   = 4'($urandom);
      step();
      vectors++;
      if (rd_valid !== m_rdv || irq !== m_irq || (m_rdv && rdata !== m_rdata)) begin
        miscompares++;
        $display("[TB] FAIL random cyc%0d: got rdv=%b rdata=%h irq=%b expected rdv=%b rdata=%h irq=%b",
                 k, rd_valid, rdata, irq, m_rdv, m_rdata, m_irq);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0; cnt_zero = 4'b0; cap_in = 4'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t reached, limit 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    cnt_zero = '0; cap_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    Rst_n = 1'b1;
    test_reset();
    test_reset_mid_count();
    test_auto_reload();
    test_overflow();
    test_w1c_race();
    test_cnt_zero();
    test_back_to_back();
    test_capture();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
